maxpool_stream_ctrl: RTL and testbench

//  Sequencer for the 2x2 stride-2 max-pool datapath. Tracks raster position of an incoming

---
 rtl/maxpool_stream_ctrl_if.sv | 35 +++
 rtl/maxpool_stream_ctrl.sv | 145 ++++++++++++++
 tb/tb_maxpool_stream_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_stream_ctrl_if.sv
// rtl/maxpool_stream_ctrl_if.sv - handshake and strobe bundle for the max-pool sequencer
interface maxpool_stream_ctrl_if #(
    parameter int CNT_W  = 7,
    parameter int ADDR_W = 6
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              out_ready;
    logic              out_valid;
    logic              hmax_load;
    logic              hmax_cmp;
    logic              lb_wr_en;
    logic              lb_rd_en;
    logic [ADDR_W-1:0] lb_addr;
    logic              out_load;
    logic [CNT_W-1:0]  out_row;
    logic [CNT_W-1:0]  out_col;
    logic              busy;
    logic              frame_done;

    // Upstream/downstream side: drives frame start and the stream handshakes
    modport master (
        output start, in_valid, out_ready,
        input  in_ready, out_valid, hmax_load, hmax_cmp, lb_wr_en, lb_rd_en,
        input  lb_addr, out_load, out_row, out_col, busy, frame_done
    );

    // Controller side
    modport slave (
        input  start, in_valid, out_ready,
        output in_ready, out_valid, hmax_load, hmax_cmp, lb_wr_en, lb_rd_en,
        output lb_addr, out_load, out_row, out_col, busy, frame_done
    );
endinterface

// File: rtl/maxpool_stream_ctrl.sv
// rtl/maxpool_stream_ctrl.sv - raster sequencer for a 2x2 stride-2 max-pool datapath
module maxpool_stream_ctrl #(
    parameter int IMG_SIZE = 100,
    parameter int CNT_W    = 7,
    parameter int ADDR_W   = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    maxpool_stream_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Rows/cols at or beyond this limit belong to no 2x2 window (odd image sizes)
    localparam logic [31:0]      POOL_LIM = 32'(2 * (IMG_SIZE / 2));
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_SIZE - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] out_row_q, out_row_d;
    logic [CNT_W-1:0] out_col_q, out_col_d;
    logic             out_valid_q, out_valid_d;

    logic stall;
    logic in_ready;
    logic accept;
    logic last_col;
    logic last_pix;
    logic in_region;
    logic hmax_load;
    logic lb_wr_en;
    logic lb_rd_en;
    logic out_load;

    // Holding input while an unconsumed result sits in the output register
    // guarantees that result is never overwritten by the next window.
    assign stall     = out_valid_q && !bus.out_ready;
    assign in_ready  = (state_q == S_RUN) && !stall;
    assign accept    = bus.in_valid && in_ready;
    assign last_col  = (col_q == LAST_IDX);
    assign last_pix  = last_col && (row_q == LAST_IDX);
    assign in_region = (32'(row_q) < POOL_LIM) && (32'(col_q) < POOL_LIM);

    // Per-pixel datapath strobes, chosen by the parity of the raster position
    always_comb begin
        hmax_load = 1'b0;
        lb_wr_en  = 1'b0;
        lb_rd_en  = 1'b0;
        out_load  = 1'b0;
        if (accept && in_region) begin
            unique case ({row_q[0], col_q[0]})
                2'b00: hmax_load = 1'b1;
                2'b01: lb_wr_en  = 1'b1;
                2'b10: begin
                    hmax_load = 1'b1;
                    lb_rd_en  = 1'b1;
                end
                default: out_load = 1'b1;
            endcase
        end
    end

    // Output register valid flag and the pooled coordinates of its content
    always_comb begin
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        if (out_load) begin
            out_valid_d = 1'b1;
            out_row_d   = row_q >> 1;
            out_col_d   = col_q >> 1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Frame FSM next state and raster counters
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_pix ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_RUN: begin
                if (accept && last_pix) state_d = S_DRAIN;
            end
            // Leave as soon as the final result is handed off this cycle
            S_DRAIN: begin
                if (!out_valid_d) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and output-register bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.hmax_load  = hmax_load;
    assign bus.hmax_cmp   = 1'b0;
    assign bus.lb_wr_en   = lb_wr_en;
    assign bus.lb_rd_en   = lb_rd_en;
    assign bus.lb_addr    = ADDR_W'(col_q >> 1);
    assign bus.out_load   = out_load;
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
    assign bus.busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.frame_done = (state_q == S_DONE);
endmodule

// File: tb/tb_maxpool_stream_ctrl.sv
// tb/tb_maxpool_stream_ctrl.sv - randomized model-checked bench for maxpool_stream_ctrl
module tb_maxpool_stream_ctrl;
    localparam int CNT_W  = 3;
    localparam int ADDR_W = 2;
    localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

    typedef struct {
        int r;
        int c;
        int v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start_v, in_valid_v, out_ready_v;
    bit   use5;

    always #5 clk = ~clk;

    maxpool_stream_ctrl_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) if4 ();
    maxpool_stream_ctrl_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) if5 ();

    maxpool_stream_ctrl #(.IMG_SIZE(4), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut4 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (if4)
    );
    maxpool_stream_ctrl #(.IMG_SIZE(5), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut5 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (if5)
    );

    assign if4.start     = start_v & ~use5;
    assign if4.in_valid  = in_valid_v & ~use5;
    assign if4.out_ready = out_ready_v & ~use5;
    assign if5.start     = start_v & use5;
    assign if5.in_valid  = in_valid_v & use5;
    assign if5.out_ready = out_ready_v & use5;

    logic              o_in_ready, o_out_valid, o_hmax_load, o_hmax_cmp, o_lb_wr, o_lb_rd;
    logic              o_out_load, o_busy, o_done;
    logic [ADDR_W-1:0] o_lb_addr;
    logic [CNT_W-1:0]  o_out_row, o_out_col;

    assign o_in_ready  = use5 ? if5.in_ready   : if4.in_ready;
    assign o_out_valid = use5 ? if5.out_valid  : if4.out_valid;
    assign o_hmax_load = use5 ? if5.hmax_load  : if4.hmax_load;
    assign o_hmax_cmp  = use5 ? if5.hmax_cmp   : if4.hmax_cmp;
    assign o_lb_wr     = use5 ? if5.lb_wr_en   : if4.lb_wr_en;
    assign o_lb_rd     = use5 ? if5.lb_rd_en   : if4.lb_rd_en;
    assign o_lb_addr   = use5 ? if5.lb_addr    : if4.lb_addr;
    assign o_out_load  = use5 ? if5.out_load   : if4.out_load;
    assign o_out_row   = use5 ? if5.out_row    : if4.out_row;
    assign o_out_col   = use5 ? if5.out_col    : if4.out_col;
    assign o_busy      = use5 ? if5.busy       : if4.busy;
    assign o_done      = use5 ? if5.frame_done : if4.frame_done;

    int   vectors = 0;
    int   miscompares = 0;
    int   img, npix, phase, acc, cyc, last_acc_cyc, done_cyc, outs_seen;
    int   pix[25];
    exp_t q[$];
    int   hmax, rd, outreg;
    int   lb[4];

    task automatic check_eq(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int window_max(input int pr, input int pc);
        int m;
        m = pix[(2*pr)*img + 2*pc];
        m = mx(m, pix[(2*pr)*img + 2*pc + 1]);
        m = mx(m, pix[(2*pr+1)*img + 2*pc]);
        m = mx(m, pix[(2*pr+1)*img + 2*pc + 1]);
        return m;
    endfunction

    // One clock cycle: drive, check at negedge, advance the reference model
    task automatic step(input bit s, input bit iv, input bit orr);
        bit   e_ov, e_ir, acc_now, e_hl, e_wr, e_rd, e_ol;
        int   r, c, lim, p, nh, nrd, nout;
        exp_t e;
        start_v = s; in_valid_v = iv; out_ready_v = orr;
        @(negedge clk);
        e_ov    = (q.size() > 0);
        e_ir    = (phase == P_RUN) && !(e_ov && !orr);
        acc_now = iv && e_ir;
        check_eq("busy", int'(o_busy), int'(phase == P_RUN || phase == P_DRAIN));
        check_eq("frame_done", int'(o_done), int'(phase == P_DONE));
        check_eq("in_ready", int'(o_in_ready), int'(e_ir));
        check_eq("out_valid", int'(o_out_valid), int'(e_ov));
        check_eq("hmax_cmp", int'(o_hmax_cmp), 0);
        if (e_ov) begin
            check_eq("out_row", int'(o_out_row), q[0].r);
            check_eq("out_col", int'(o_out_col), q[0].c);
        end
        r = acc / img; c = acc % img; lim = 2 * (img / 2);
        e_hl = 0; e_wr = 0; e_rd = 0; e_ol = 0;
        if (acc_now && r < lim && c < lim) begin
            e_hl = (c % 2 == 0);
            e_rd = (r % 2 == 1) && (c % 2 == 0);
            e_wr = (r % 2 == 0) && (c % 2 == 1);
            e_ol = (r % 2 == 1) && (c % 2 == 1);
        end
        check_eq("hmax_load", int'(o_hmax_load), int'(e_hl));
        check_eq("lb_wr_en", int'(o_lb_wr), int'(e_wr));
        check_eq("lb_rd_en", int'(o_lb_rd), int'(e_rd));
        check_eq("out_load", int'(o_out_load), int'(e_ol));
        if (e_wr || e_rd || e_ol) check_eq("lb_addr", int'(o_lb_addr), c / 2);
        if (e_ov && orr) begin
            check_eq("pooled_value", outreg, q[0].v);
            void'(q.pop_front());
            outs_seen++;
        end
        p = acc_now ? pix[acc] : 0;
        nh = hmax; nrd = rd; nout = outreg;
        if (o_hmax_load) nh = p;
        if (o_lb_rd) nrd = lb[o_lb_addr];
        if (o_lb_wr) lb[o_lb_addr] = mx(hmax, p);
        if (o_out_load) nout = mx(mx(hmax, p), rd);
        hmax = nh; rd = nrd; outreg = nout;
        if (e_ol) begin
            e.r = r / 2; e.c = c / 2; e.v = window_max(r / 2, c / 2);
            q.push_back(e);
        end
        if (phase == P_DONE) done_cyc = cyc;
        if (acc_now) last_acc_cyc = cyc;
        case (phase)
            P_IDLE:  if (s) begin phase = P_RUN; acc = 0; end
            P_RUN:   if (acc_now) begin acc++; if (acc == npix) phase = P_DRAIN; end
            P_DRAIN: if (q.size() == 0) phase = P_DONE;
            default: phase = P_IDLE;
        endcase
        @(posedge clk); #1;
        cyc++;
    endtask

    // Modes: 0 streaming 0..N-1, 1 five-cycle stall after first output,
    // 2 In_Valid toggling, 3 random. rst_at >= 0 aborts by reset after that many pixels.
    task automatic run_frame(input int mode, input int rst_at);
        int  budget, stall_left, t;
        bit  trig, iv, orr, s;
        img = use5 ? 5 : 4; npix = img * img;
        for (int k = 0; k < npix; k++) pix[k] = (mode == 0) ? k : int'($urandom_range(0, 255));
        outs_seen = 0; stall_left = 5; trig = 0; t = 0; done_cyc = -1;
        step(1'b1, 1'b0, 1'b1);
        budget = 400;
        while (phase != P_IDLE && budget > 0) begin
            if (rst_at >= 0 && acc == rst_at) begin
                rst_n = 1'b0; in_valid_v = 1'b1; start_v = 1'b0;
                @(negedge clk);
                check_eq("rst_in_ready", int'(o_in_ready), 0);
                check_eq("rst_out_valid", int'(o_out_valid), 0);
                check_eq("rst_busy", int'(o_busy), 0);
                check_eq("rst_out_row", int'(o_out_row), 0);
                phase = P_IDLE; q.delete(); acc = 0;
                @(posedge clk); #1;
                rst_n = 1'b1; in_valid_v = 1'b0;
                return;
            end
            iv = 1'b1; orr = 1'b1; s = 1'b0;
            case (mode)
                1: begin
                    if (!trig && q.size() > 0) trig = 1;
                    if (trig && stall_left > 0) begin orr = 1'b0; stall_left--; end
                end
                2: iv = (t % 2 == 0);
                3: begin
                    iv  = ($urandom_range(0, 3) != 0);
                    orr = ($urandom_range(0, 2) != 0);
                    s   = ($urandom_range(0, 7) == 0);
                end
                default: ;
            endcase
            step(s, iv, orr);
            t++; budget--;
        end
        check_eq("frame_timeout", int'(budget == 0), 0);
        check_eq("outputs_per_frame", outs_seen, (img / 2) * (img / 2));
        if (mode == 0) check_eq("done_latency", done_cyc - last_acc_cyc, 2);
        start_v = 1'b0; in_valid_v = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_v = 1'b0; in_valid_v = 1'b0; out_ready_v = 1'b0;
        use5 = 1'b0; phase = P_IDLE; acc = 0; cyc = 0; last_acc_cyc = 0;
        hmax = 0; rd = 0; outreg = 0; img = 4; npix = 16;
        for (int i = 0; i < 4; i++) lb[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_in_ready", int'(o_in_ready), 0);
        check_eq("reset_out_valid", int'(o_out_valid), 0);
        check_eq("reset_busy", int'(o_busy), 0);
        check_eq("reset_frame_done", int'(o_done), 0);
        check_eq("reset_out_row", int'(o_out_row), 0);
        check_eq("reset_out_col", int'(o_out_col), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(2, -1);
        for (int i = 0; i < 4; i++) run_frame(3, -1);
        run_frame(3, 10);
        run_frame(0, -1);
        run_frame(1, -1);
        use5 = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        run_frame(0, -1);
        run_frame(2, -1);
        for (int i = 0; i < 3; i++) run_frame(3, -1);
        run_frame(3, 13);
        run_frame(1, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
